// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: absorbs a serial message, then either emits the
// CRC LSB-first (generate) or flags the residue (check).
module crc_serial_engine #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h44,
    parameter logic [WIDTH-1:0] SEED  = 8'hD8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             active,
    input  logic             check_mode,
    input  logic             abort,
    output logic             crc_out,
    output logic             valid,
    output logic [WIDTH-1:0] crc_par,
    output logic             crc_par_valid,
    output logic             busy,
    output logic             check_ok,
    output logic             check_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    // The MSB tap bit has no effect: the MSB always takes the feedback bit.
    localparam logic [WIDTH-1:0] TMASK = {1'b0, TAPS[WIDTH-2:0]};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [CW-1:0]    cnt;
    logic             mode_q;

    // One absorb step of the right-shifting Galois LFSR.
    function automatic logic [WIDTH-1:0] step(
        input logic [WIDTH-1:0] s,
        input logic             d
    );
        logic fb;
        fb = d ^ s[0];
        return {fb, s[WIDTH-1:1]} ^ ({WIDTH{fb}} & TMASK);
    endfunction

    assign busy = (state != IDLE);

    // Control FSM with LFSR, counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            lfsr          <= SEED;
            cnt           <= '0;
            mode_q        <= 1'b0;
            crc_out       <= 1'b0;
            valid         <= 1'b0;
            crc_par       <= '0;
            crc_par_valid <= 1'b0;
            check_ok      <= 1'b0;
            check_err     <= 1'b0;
        end else begin
            crc_out       <= 1'b0;
            valid         <= 1'b0;
            crc_par_valid <= 1'b0;
            check_ok      <= 1'b0;
            check_err     <= 1'b0;
            if (abort) begin
                state <= IDLE;
                lfsr  <= SEED;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (active) begin
                            lfsr   <= step(SEED, data_in);
                            mode_q <= check_mode;
                            cnt    <= '0;
                            state  <= CALC;
                        end
                    end
                    CALC: begin
                        if (active) begin
                            lfsr <= step(lfsr, data_in);
                        end else if (!mode_q) begin
                            crc_par       <= lfsr;
                            crc_par_valid <= 1'b1;
                            crc_out       <= lfsr[0];
                            valid         <= 1'b1;
                            lfsr          <= lfsr >> 1;
                            cnt           <= CW'(1);
                            state         <= EMIT;
                        end else begin
                            crc_par       <= lfsr;
                            crc_par_valid <= 1'b1;
                            check_ok      <= (lfsr == '0);
                            check_err     <= (lfsr != '0);
                            lfsr          <= SEED;
                            state         <= IDLE;
                        end
                    end
                    EMIT: begin
                        if (active) begin
                            lfsr   <= step(SEED, data_in);
                            mode_q <= check_mode;
                            cnt    <= '0;
                            state  <= CALC;
                        end else if (cnt == LAST) begin
                            lfsr  <= SEED;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            crc_out <= lfsr[0];
                            valid   <= 1'b1;
                            lfsr    <= lfsr >> 1;
                            cnt     <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        lfsr  <= SEED;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: default 8-bit instance plus a
// 16-bit (0x8408 taps, 0xFFFF seed) instance against a reference model.
module tb_crc_serial_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 8-bit default instance
    logic       a8 = 0, d8 = 0, m8 = 0, ab8 = 0;
    logic       co8, v8, cpv8, b8, ok8, er8;
    logic [7:0] cp8;

    // 16-bit instance
    logic        a16 = 0, d16 = 0, m16 = 0, ab16 = 0;
    logic        co16, v16, cpv16, b16, ok16, er16;
    logic [15:0] cp16;

    crc_serial_engine u8 (
        .clk(clk), .rst(rst), .data_in(d8), .active(a8),
        .check_mode(m8), .abort(ab8), .crc_out(co8), .valid(v8),
        .crc_par(cp8), .crc_par_valid(cpv8), .busy(b8),
        .check_ok(ok8), .check_err(er8)
    );

    crc_serial_engine #(
        .WIDTH(16), .TAPS(16'h8408), .SEED(16'hFFFF)
    ) u16 (
        .clk(clk), .rst(rst), .data_in(d16), .active(a16),
        .check_mode(m16), .abort(ab16), .crc_out(co16), .valid(v16),
        .crc_par(cp16), .crc_par_valid(cpv16), .busy(b16),
        .check_ok(ok16), .check_err(er16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present n bits LSB-first; leaves active low before the end edge.
    task automatic send8(input logic [127:0] bits, input int n,
                         input logic mode);
        for (int i = 0; i < n; i++) begin
            a8 = 1; d8 = bits[i]; m8 = mode;
            tick();
        end
        a8 = 0; d8 = 0;
    endtask

    task automatic send16(input logic [127:0] bits, input int n,
                          input logic mode);
        for (int i = 0; i < n; i++) begin
            a16 = 1; d16 = bits[i]; m16 = mode;
            tick();
        end
        a16 = 0; d16 = 0;
    endtask

    // Reference CRC written per bit from the LFSR equations.
    function automatic logic [15:0] ref16(input logic [63:0] msg,
                                          input int n);
        logic [15:0] s, t;
        logic        fb;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = msg[i] ^ s[0];
            t[15] = fb;
            for (int j = 0; j < 15; j++) begin
                t[j] = s[j+1] ^ (((16'h8408 >> j) & 16'h1) != 0 ? fb : 1'b0);
            end
            s = t;
        end
        return s;
    endfunction

    // Run one 8-bit generate message and collect the serial output.
    task automatic gen8(input logic [127:0] bits, input int n,
                        output logic [7:0] par, output logic [7:0] ser,
                        output int nvalid, output int npulse);
        send8(bits, n, 1'b0);
        tick();
        par = cp8;
        ser = '0; nvalid = 0; npulse = 0;
        for (int k = 0; k < 12; k++) begin
            if (cpv8) npulse++;
            if (v8) begin
                if (nvalid < 8) ser[nvalid] = co8;
                nvalid++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 0;
        #3;
        tests++;
        if ({co8, v8, cp8, cpv8, b8, ok8, er8} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=0",
                     {co8, v8, cp8, cpv8, b8, ok8, er8});
        end
        tests++;
        if ({v16, cp16, b16} !== 18'h0) begin
            fails++;
            $display("FAIL reset_outputs16 got=%h want=0", {v16, cp16, b16});
        end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_gen_zero();
        logic [7:0] par, ser;
        int nv, np;
        gen8(128'h0, 1, par, ser, nv, np);
        tests++;
        if (par !== 8'h6C) begin
            fails++; $display("FAIL gen0_par got=%h want=6c", par);
        end
        tests++;
        if (ser !== 8'h6C) begin
            fails++; $display("FAIL gen0_serial got=%h want=6c", ser);
        end
        tests++;
        if (nv != 8 || np != 1) begin
            fails++;
            $display("FAIL gen0_counts valid=%0d pulse=%0d want 8 1", nv, np);
        end
        tests++;
        if (b8 !== 1'b0) begin
            fails++; $display("FAIL gen0_busy got=%b want=0", b8);
        end
    endtask

    task automatic test_gen_one();
        logic [7:0] par, ser;
        int nv, np;
        gen8(128'h1, 1, par, ser, nv, np);
        tests++;
        if (par !== 8'hA8) begin
            fails++; $display("FAIL gen1_par got=%h want=a8", par);
        end
        tests++;
        if (ser !== 8'hA8 || nv != 8) begin
            fails++;
            $display("FAIL gen1_serial got=%h n=%0d want=a8 n=8", ser, nv);
        end
    endtask

    task automatic test_check();
        // message bit 1 followed by 0xA8 LSB-first
        send8(128'h151, 9, 1'b1);
        tick();
        tests++;
        if (ok8 !== 1'b1 || er8 !== 1'b0 || v8 !== 1'b0) begin
            fails++;
            $display("FAIL check_good ok=%b err=%b valid=%b want 1 0 0",
                     ok8, er8, v8);
        end
        tick();
        tests++;
        if (ok8 !== 1'b0 || b8 !== 1'b0) begin
            fails++;
            $display("FAIL check_pulse ok=%b busy=%b want 0 0", ok8, b8);
        end
        send8(128'h051, 9, 1'b1);
        tick();
        tests++;
        if (ok8 !== 1'b0 || er8 !== 1'b1 || v8 !== 1'b0) begin
            fails++;
            $display("FAIL check_bad ok=%b err=%b valid=%b want 0 1 0",
                     ok8, er8, v8);
        end
        tick();
    endtask

    task automatic test_truncate();
        int nv;
        logic [7:0] ser;
        send8(128'h1, 1, 1'b0);
        nv = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (v8) nv++;
        end
        a8 = 1; d8 = 0; m8 = 0;
        tick();
        a8 = 0;
        tests++;
        if (nv != 3 || v8 !== 1'b0 || b8 !== 1'b1) begin
            fails++;
            $display("FAIL trunc_stop bits=%0d valid=%b busy=%b want 3 0 1",
                     nv, v8, b8);
        end
        tick();
        tests++;
        if (cp8 !== 8'h6C || cpv8 !== 1'b1) begin
            fails++;
            $display("FAIL trunc_par got=%h pv=%b want=6c 1", cp8, cpv8);
        end
        ser = '0; nv = 0;
        for (int k = 0; k < 12; k++) begin
            if (v8) begin
                if (nv < 8) ser[nv] = co8;
                nv++;
            end
            tick();
        end
        tests++;
        if (ser !== 8'h6C || nv != 8) begin
            fails++;
            $display("FAIL trunc_serial got=%h n=%0d want=6c n=8", ser, nv);
        end
    endtask

    task automatic test_abort();
        int seen;
        a8 = 1; d8 = 1; m8 = 0;
        tick();
        tick();
        ab8 = 1; a8 = 0;
        tick();
        ab8 = 0;
        tests++;
        if (b8 !== 1'b0 || v8 !== 1'b0 || cpv8 !== 1'b0) begin
            fails++;
            $display("FAIL abort_now busy=%b valid=%b pv=%b want 0 0 0",
                     b8, v8, cpv8);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (v8 || cpv8) seen++;
            tick();
        end
        tests++;
        if (seen != 0 || cp8 !== 8'h6C) begin
            fails++;
            $display("FAIL abort_after outs=%0d par=%h want 0 6c", seen, cp8);
        end
    endtask

    task automatic test_reset_mid_emit();
        logic [7:0] par, ser;
        int nv, np;
        send8(128'h1, 1, 1'b0);
        tick();
        tick();
        #2 rst = 0;
        #1;
        tests++;
        if ({co8, v8, cp8, cpv8, b8, ok8, er8} !== 14'h0) begin
            fails++;
            $display("FAIL rst_mid_emit got=%h want=0",
                     {co8, v8, cp8, cpv8, b8, ok8, er8});
        end
        #2 rst = 1;
        tick();
        gen8(128'h0, 1, par, ser, nv, np);
        tests++;
        if (par !== 8'h6C || ser !== 8'h6C || nv != 8) begin
            fails++;
            $display("FAIL rst_regen par=%h ser=%h n=%0d want 6c 6c 8",
                     par, ser, nv);
        end
    endtask

    task automatic test_random16();
        logic [63:0]  msg;
        logic [127:0] vec;
        logic [15:0]  exp;
        int           n;
        for (int t = 0; t < 8; t++) begin
            n = (t == 0) ? 1 : (t == 1) ? 64 : int'($urandom_range(1, 64));
            msg = {$urandom, $urandom};
            exp = ref16(msg, n);
            send16({64'h0, msg}, n, 1'b0);
            tick();
            tests++;
            if (cp16 !== exp || cpv16 !== 1'b1) begin
                fails++;
                $display("FAIL rand16_par n=%0d got=%h want=%h", n, cp16, exp);
            end
            for (int k = 0; k < 18; k++) tick();
            vec = {64'h0, msg};
            for (int i = n; i < 128; i++) vec[i] = 1'b0;
            vec = vec | ({112'h0, exp} << n);
            send16(vec, n + 16, 1'b1);
            tick();
            tests++;
            if (ok16 !== 1'b1 || er16 !== 1'b0 || v16 !== 1'b0) begin
                fails++;
                $display("FAIL rand16_check n=%0d ok=%b err=%b want 1 0",
                         n, ok16, er16);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_gen_zero();
        test_gen_one();
        test_check();
        test_truncate();
        test_abort();
        test_reset_mid_emit();
        test_random16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Parametrised bit-serial CRC engine; successor to the team's fixed 8-bit serial CRC generator.
- Two modes, chosen per message:
  - Generate: absorbs a serial message while `active` is high, then emits the WIDTH-bit CRC LSB-first on `crc_out` and presents it in parallel.
  - Check: message with its appended CRC is absorbed, then the residue is flagged pass/fail.
- Sits between the serial link framer and the packet controller.

Parameters:
- WIDTH, 8, CRC/LFSR width (4..32).
- TAPS, 8'h44, tap mask. TAPS[i]=1 means bit i receives an XOR with feedback (i < WIDTH-1). Bit WIDTH-1 is ignored.
- SEED, 8'hD8, LFSR load value at reset, on abort and at message start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- data_in  in  1  serial message bit, sampled when active=1.
- active  in  1  high while message bits are presented; one bit per cycle.
- check_mode  in  1  0=generate, 1=check; sampled on the first active cycle of a message.
- abort  in  1  synchronous abort; priority over active.
- crc_out  out  1  serial CRC bit, LSB first.
- valid  out  1  qualifies crc_out.
- crc_par  out  WIDTH  CRC value, held until the next capture.
- crc_par_valid  out  1  one-cycle pulse when crc_par is updated.
- busy  out  1  high in CALC or EMIT.
- check_ok  out  1  one-cycle pulse: residue == 0 at end of a check message.
- check_err  out  1  one-cycle pulse: residue != 0 at end of a check message.

Behaviour:
- Reset (rst=0, async):
  - LFSR=SEED, state=IDLE, counter=0.
  - All outputs 0, including crc_par.
- Feedback: fb = data_in ^ LFSR[0].
  - LFSR[WIDTH-1] <= fb.
  - LFSR[i] <= LFSR[i+1] ^ (TAPS[i] & fb) for i < WIDTH-1.
- Absorb rule: every cycle with active=1 (and abort=0) absorbs one bit. A message starting from IDLE absorbs its first bit from SEED.
- FSM states: IDLE, CALC, EMIT.
- IDLE:
  - active=1 -> absorb the bit, latch check_mode into mode_q, go to CALC.
- CALC:
  - active=1 -> absorb.
  - active=0 and mode_q=0 -> go to EMIT:
    - crc_par<=LFSR and crc_par_valid=1.
    - crc_out<=LFSR[0] and valid=1, all registered in the same edge.
    - LFSR shifts right with 0 into the MSB.
    - counter=1.
  - active=0 and mode_q=1 -> crc_par<=LFSR; check_ok=(LFSR==0) or check_err=(LFSR!=0), pulsed on the next cycle; LFSR<=SEED; go to IDLE. valid is never asserted in check mode.
- EMIT:
  - Each cycle: crc_out<=LFSR[0], valid=1, LFSR shifts right with 0 in, counter++.
  - valid is high for exactly WIDTH consecutive cycles.
  - After the WIDTH-th bit: valid<=0, LFSR<=SEED, go to IDLE.
- Latency: first valid bit appears on the clock edge at which active is first sampled low.
- active=1 during EMIT:
  - Emission is truncated; valid=0 next cycle.
  - LFSR is loaded with SEED advanced by that cycle's data_in (new message starts).
  - check_mode is re-latched; go to CALC.
- abort=1 in any state:
  - Next edge: state=IDLE, LFSR=SEED, counter=0.
  - valid, crc_par_valid, check pulses and busy go to 0. crc_out=0.
  - crc_par is unchanged.
- busy=1 exactly when state is CALC or EMIT.
- Counter width is clog2(WIDTH+1). It never wraps.
- Residue property: in check mode, feeding a message followed by its generated CRC LSB-first yields residue 0.

Test Plan:
- Reset mid-EMIT (drop rst for 1 cycle) -> all outputs 0 immediately; LFSR=SEED; next message gives the same CRC as from power-up.
- Defaults, generate mode, 1-bit message data_in=0 -> crc_par=8'h6C, crc_par_valid pulse; crc_out sequence 0,0,1,1,0,1,1,0 with valid high exactly 8 cycles; busy low afterwards.
- Defaults, 1-bit message data_in=1 -> crc_par=8'hA8; serial 0,0,0,1,0,1,0,1.
- Check mode, bits 1,0,0,0,1,0,1,0,1 (message 1 followed by CRC 8'hA8 LSB-first) -> check_ok pulse, no check_err, valid never high.
  - Same with the last bit flipped -> check_err pulse.
- active reasserted on the 3rd EMIT cycle with data_in=0, for 1 cycle -> valid drops after 3 bits; second message result crc_par=8'h6C, 8 full valid bits.
- abort asserted in CALC -> busy=0 next cycle; no valid or crc_par_valid.
- Random messages (1..64 bits) with WIDTH=16, TAPS=16'h8408, SEED=16'hFFFF -> crc_par matches the bench reference model bit-for-bit.
  - Check mode on message+CRC -> check_ok every time.
